register_bank_2r1w: RTL and testbench

- Parametrised successor to the single flip-flop register: a bank of NrOfRegs words, NrOfBits wide, with one write port and two read ports.
- Adds byte-lane write masks, an optional hardwired-zero register 0, and write-to-read bypass.
- Adds a sequenced bulk-fill engine that writes a fill value into every register, one per ticked cycle.
- Sits in the datapath as the CPU general-purpose register file. Read outputs keep the per-port tri-state select for bus sharing.

---
 rtl/register_bank_2r1w.sv | 159 +++++++++++++++
 tb/tb_register_bank_2r1w.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_2r1w.sv
// register_bank_2r1w
//   CPU general-purpose register file: NrOfRegs words of NrOfBits, one
//   byte-masked write port, two combinational read ports with optional
//   write-to-read bypass, optional hardwired-zero register 0, and a bulk-fill
//   engine that writes a latched value into every register, one per advance.
//
// Ports
//   Clock_i        rising-edge clock
//   Reset_i        async active-low reset (registers, FSM, Busy)
//   ClockEnable_i  global write qualifier
//   Tick_i         tick qualifier; state advances only on ClockEnable_i & Tick_i
//   WE_i           write request
//   WAddr_i        write address
//   WData_i        write data
//   ByteEn_i       per-byte write mask, bit i covers bits [8i+7:8i]
//   RAddr1_i/2_i   read addresses
//   cs1_i/cs2_i    1 = matching read port floats (high-Z)
//   FillStart_i    start bulk fill
//   FillValue_i    value written during the fill
//   RData1_o/2_o   read data
//   Busy_o         high while the fill runs
module register_bank_2r1w #(
    parameter int NrOfBits = 32,
    parameter int NrOfRegs = 32,
    parameter int AddrBits = 5,
    parameter int ZeroReg0 = 1,
    parameter int Bypass   = 1
) (
    input  logic                  Clock_i,
    input  logic                  Reset_i,
    input  logic                  ClockEnable_i,
    input  logic                  Tick_i,
    input  logic                  WE_i,
    input  logic [AddrBits-1:0]   WAddr_i,
    input  logic [NrOfBits-1:0]   WData_i,
    input  logic [NrOfBits/8-1:0] ByteEn_i,
    input  logic [AddrBits-1:0]   RAddr1_i,
    input  logic [AddrBits-1:0]   RAddr2_i,
    input  logic                  cs1_i,
    input  logic                  cs2_i,
    input  logic                  FillStart_i,
    input  logic [NrOfBits-1:0]   FillValue_i,
    output logic [NrOfBits-1:0]   RData1_o,
    output logic [NrOfBits-1:0]   RData2_o,
    output logic                  Busy_o
);

    localparam int NB   = NrOfBits / 8;
    localparam int IdxW = (NrOfRegs > 1) ? $clog2(NrOfRegs) : 1;
    localparam logic [AddrBits:0]   NRegs   = (AddrBits+1)'(NrOfRegs);
    localparam logic [AddrBits-1:0] LastPtr = AddrBits'(NrOfRegs - 1);

    typedef enum logic {IDLE, FILL} state_e;

    state_e              state_q;
    logic [AddrBits-1:0] ptr_q;
    logic [NrOfBits-1:0] fill_q;
    logic                busy_q;

    logic [NrOfBits-1:0] words [NrOfRegs];

    logic adv;
    logic user_wr;   // accepted user write this edge
    logic fill_wr;   // fill engine writes reg[ptr_q] this edge
    logic byp_ok;    // bypass window (address match checked per port)

    assign adv     = ClockEnable_i & Tick_i;
    assign user_wr = adv & (state_q == IDLE) & WE_i & ~FillStart_i;
    assign fill_wr = adv & (state_q == FILL);
    assign byp_ok  = (Bypass != 0) & adv & (state_q == IDLE) & WE_i;

    function automatic logic [NrOfBits-1:0] merge_bytes(
        input logic [NrOfBits-1:0] old_w,
        input logic [NrOfBits-1:0] new_w,
        input logic [NB-1:0]       be
    );
        logic [NrOfBits-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------- fill FSM (single sequential block) ----------------
    always_ff @(posedge Clock_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
        end else if (adv) begin
            case (state_q)
                IDLE: if (FillStart_i) begin
                    state_q <= FILL;
                    ptr_q   <= '0;
                    fill_q  <= FillValue_i;
                    busy_q  <= 1'b1;
                end
                FILL: if (ptr_q == LastPtr) begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                    busy_q  <= 1'b0;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy_o = busy_q;

    // ---------------- storage ----------------
    // Address compares against AddrBits'(r) only match r < NrOfRegs, so
    // out-of-range writes never reach any register.
    for (genvar r = 0; r < NrOfRegs; r++) begin : g_reg
        if (ZeroReg0 != 0 && r == 0) begin : g_zero
            assign words[r] = '0;
        end else begin : g_ff
            logic [NrOfBits-1:0] word_q, word_d;

            always_comb begin
                word_d = word_q;
                if (fill_wr && ptr_q == AddrBits'(r))
                    word_d = fill_q;
                else if (user_wr && WAddr_i == AddrBits'(r))
                    word_d = merge_bytes(word_q, WData_i, ByteEn_i);
            end

            always_ff @(posedge Clock_i or negedge Reset_i) begin
                if (!Reset_i) word_q <= '0;
                else          word_q <= word_d;
            end

            assign words[r] = word_q;
        end
    end

    // ---------------- read ports ----------------
    function automatic logic [NrOfBits-1:0] rd_value(input logic [AddrBits-1:0] ra);
        logic [NrOfBits-1:0] v;
        v = '0;
        if ({1'b0, ra} < NRegs && !(ZeroReg0 != 0 && ra == '0)) begin
            if (byp_ok && WAddr_i == ra)
                v = merge_bytes(words[IdxW'(ra)], WData_i, ByteEn_i);
            else
                v = words[IdxW'(ra)];
        end
        return v;
    endfunction

    logic [NrOfBits-1:0] rd1, rd2;
    assign rd1 = rd_value(RAddr1_i);
    assign rd2 = rd_value(RAddr2_i);

    assign RData1_o = cs1_i ? {NrOfBits{1'bz}} : rd1;
    assign RData2_o = cs2_i ? {NrOfBits{1'bz}} : rd2;

endmodule

// File: tb/tb_register_bank_2r1w.sv
module tb_register_bank_2r1w;

    logic        clk, rst_n, ce, tick, we, fs, cs1, cs2;
    logic [5:0]  waddr, ra1, ra2;
    logic [31:0] wdata, fv;
    logic [3:0]  be;
    wire  [31:0] r1_0, r2_0, r1_1, r2_1;
    wire         busy0, busy1;

    int ncmp = 0;
    int nerr = 0;

    // dut0: defaults (5-bit address, zero reg0) -- sees the low 5 address bits
    register_bank_2r1w dut0 (
        .Clock_i(clk), .Reset_i(rst_n), .ClockEnable_i(ce), .Tick_i(tick),
        .WE_i(we), .WAddr_i(waddr[4:0]), .WData_i(wdata), .ByteEn_i(be),
        .RAddr1_i(ra1[4:0]), .RAddr2_i(ra2[4:0]), .cs1_i(cs1), .cs2_i(cs2),
        .FillStart_i(fs), .FillValue_i(fv),
        .RData1_o(r1_0), .RData2_o(r2_0), .Busy_o(busy0));

    // dut1: 6-bit address over 32 regs, no hardwired zero
    register_bank_2r1w #(.AddrBits(6), .ZeroReg0(0)) dut1 (
        .Clock_i(clk), .Reset_i(rst_n), .ClockEnable_i(ce), .Tick_i(tick),
        .WE_i(we), .WAddr_i(waddr), .WData_i(wdata), .ByteEn_i(be),
        .RAddr1_i(ra1), .RAddr2_i(ra2), .cs1_i(cs1), .cs2_i(cs2),
        .FillStart_i(fs), .FillValue_i(fv),
        .RData1_o(r1_1), .RData2_o(r2_1), .Busy_o(busy1));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mem [2][32];
    bit          mbusy;
    int          mptr;
    logic [31:0] mfv;

    function automatic int eff(int k, logic [5:0] a);
        return (k == 0) ? int'(a[4:0]) : int'(a);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [5:0] ra);
        int a, w;
        a = eff(k, ra);
        w = eff(k, waddr);
        if (a >= 32) return 32'h0;
        if (k == 0 && a == 0) return 32'h0;
        if (!mbusy && we && ce && tick && w == a) return merge(mem[k][a], wdata, be);
        return mem[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) for (int i = 0; i < 32; i++) mem[k][i] = 32'h0;
        mbusy = 0; mptr = 0; mfv = 32'h0;
    endtask

    task automatic model_edge();
        int w;
        if (ce && tick) begin
            if (!mbusy) begin
                if (fs) begin
                    mbusy = 1; mptr = 0; mfv = fv;
                end else if (we) begin
                    for (int k = 0; k < 2; k++) begin
                        w = eff(k, waddr);
                        if (w < 32 && !(k == 0 && w == 0)) mem[k][w] = merge(mem[k][w], wdata, be);
                    end
                end
            end else begin
                for (int k = 0; k < 2; k++)
                    if (!(k == 0 && mptr == 0)) mem[k][mptr] = mfv;
                if (mptr == 31) mbusy = 0; else mptr++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        if (!cs1) begin
            check({tag, " r1 dut0"}, r1_0, exp_rd(0, ra1));
            check({tag, " r1 dut1"}, r1_1, exp_rd(1, ra1));
        end
        if (!cs2) begin
            check({tag, " r2 dut0"}, r2_0, exp_rd(0, ra2));
            check({tag, " r2 dut1"}, r2_1, exp_rd(1, ra2));
        end
        check({tag, " busy dut0"}, {31'b0, busy0}, {31'b0, mbusy});
        check({tag, " busy dut1"}, {31'b0, busy1}, {31'b0, mbusy});
    endtask

    // inputs are driven at edge+1; check mid-cycle, then take the edge
    task automatic step(string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        ce = 0; tick = 0; we = 0; fs = 0; cs1 = 0; cs2 = 0;
        waddr = 0; wdata = 0; be = 4'hF; ra1 = 0; ra2 = 0; fv = 0;
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        ce, tick;
        logic [5:0]  ra1, ra2;
        logic [31:0] e1_0, e1_1, e2_0, e2_1;
    } vec_t;

    vec_t vt[10];
    int   busycnt;

    initial begin
        clk = 0; rst_n = 0;
        idle_inputs();
        model_reset();

        // reset state
        #3;
        for (int a = 0; a < 32; a += 7) begin
            ra1 = 6'(a); ra2 = 6'(31 - a); #1;
            check("reset r1 dut0", r1_0, 32'h0);
            check("reset r2 dut1", r2_1, 32'h0);
        end
        check("reset busy", {31'b0, busy0 | busy1}, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // directed table: byte writes, bypass, tick gating, zero reg, range
        vt[0] = '{1'b1, 6'd5,  32'h11223344, 4'hF, 1'b1, 1'b1, 6'd5,  6'd5,  32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344};
        vt[1] = '{1'b1, 6'd5,  32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 6'd5,  6'd5,  32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344};
        vt[2] = '{1'b1, 6'd5,  32'hAABBCCDD, 4'h5, 1'b1, 1'b1, 6'd5,  6'd5,  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
        vt[3] = '{1'b0, 6'd5,  32'h0,        4'hF, 1'b1, 1'b1, 6'd5,  6'd5,  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
        vt[4] = '{1'b1, 6'd0,  32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 6'd0,  6'd5,  32'h0,        32'hFFFFFFFF, 32'h11BB33DD, 32'h11BB33DD};
        vt[5] = '{1'b0, 6'd0,  32'h0,        4'hF, 1'b1, 1'b1, 6'd0,  6'd5,  32'h0,        32'hFFFFFFFF, 32'h11BB33DD, 32'h11BB33DD};
        vt[6] = '{1'b1, 6'd40, 32'h00000055, 4'hF, 1'b1, 1'b1, 6'd40, 6'd8,  32'h00000055, 32'h0,        32'h00000055, 32'h0};
        vt[7] = '{1'b0, 6'd0,  32'h0,        4'hF, 1'b1, 1'b1, 6'd8,  6'd40, 32'h00000055, 32'h0,        32'h00000055, 32'h0};
        vt[8] = '{1'b1, 6'd9,  32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 6'd9,  6'd5,  32'h0,        32'h0,        32'h11BB33DD, 32'h11BB33DD};
        vt[9] = '{1'b0, 6'd9,  32'h0,        4'hF, 1'b1, 1'b1, 6'd9,  6'd5,  32'h0,        32'h0,        32'h11BB33DD, 32'h11BB33DD};
        for (int i = 0; i < 10; i++) begin
            we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd; be = vt[i].be;
            ce = vt[i].ce; tick = vt[i].tick; ra1 = vt[i].ra1; ra2 = vt[i].ra2;
            #1;
            check($sformatf("vec%0d r1 dut0", i), r1_0, vt[i].e1_0);
            check($sformatf("vec%0d r1 dut1", i), r1_1, vt[i].e1_1);
            check($sformatf("vec%0d r2 dut0", i), r2_0, vt[i].e2_0);
            check($sformatf("vec%0d r2 dut1", i), r2_1, vt[i].e2_1);
            step("vec");
        end

        // tri-state: port 2 released, port 1 still valid
        idle_inputs(); ra1 = 5; ra2 = 5; cs2 = 1; #1;
        check("cs2 r1 valid", r1_0, 32'h11BB33DD);
        ncmp++;
        if (r2_0 === 32'h11BB33DD) begin
            nerr++; $display("FAIL cs2 release: got %h, expected not driven", r2_0);
        end
        cs2 = 0; #1;
        check("cs2 off r2", r2_0, 32'h11BB33DD);

        // async reset mid-cycle with data present
        rst_n = 0; model_reset(); #1;
        check("async rst r1 dut0", r1_0, 32'h0);
        check("async rst r2 dut1", r2_1, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // fill, continuous advance, WE during fill is ignored
        idle_inputs(); ce = 1; tick = 1; fs = 1; fv = 32'hDEADBEEF;
        step("fill start");
        fs = 0; busycnt = 0;
        for (int i = 0; i < 100 && busy0; i++) begin
            busycnt++;
            we = 1; waddr = 3; wdata = 32'h12345678;
            ra1 = 6'($urandom_range(0, 31)); ra2 = 6'(i % 32);
            step("fill");
        end
        check("fill busy cycles", busycnt, 32);
        we = 0; ce = 0;
        for (int a = 0; a < 32; a++) begin
            ra1 = 6'(a); #1;
            check($sformatf("fill reg%0d dut0", a), r1_0, (a == 0) ? 32'h0 : 32'hDEADBEEF);
            check($sformatf("fill reg%0d dut1", a), r1_1, 32'hDEADBEEF);
        end
        @(posedge clk); #1;

        // fill with tick alternating
        idle_inputs(); ce = 1; tick = 1; fs = 1; fv = 32'h5A5A0F0F;
        step("fill2 start");
        fs = 0; busycnt = 0;
        for (int i = 0; i < 200 && busy0; i++) begin
            busycnt++;
            tick = (i % 2 == 1);
            ra1 = 6'($urandom_range(0, 31));
            step("fill2");
        end
        check("fill2 busy clocks", busycnt, 64);

        // mid-fill reset at ptr==10
        idle_inputs(); ce = 1; tick = 1; fs = 1; fv = 32'h01020304;
        step("fill3 start");
        fs = 0;
        for (int i = 0; i < 10; i++) begin ra1 = 6'(i); step("fill3"); end
        rst_n = 0; model_reset(); ra1 = 9; ra2 = 1; #1;
        check("midfill rst busy", {31'b0, busy0 | busy1}, 32'h0);
        check("midfill rst r1 dut1", r1_1, 32'h0);
        check("midfill rst r2 dut0", r2_0, 32'h0);
        rst_n = 1; idle_inputs();
        @(posedge clk); #1;
        ce = 1; tick = 1; we = 1; waddr = 7; wdata = 32'h0BADC0DE;
        step("post rst wr");
        we = 0; ra1 = 7; ra2 = 20; #1;
        check("post rst rd dut0", r1_0, 32'h0BADC0DE);
        check("post rst rd dut1", r1_1, 32'h0BADC0DE);
        check("post rst r2 dut0", r2_0, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!rst_n) model_reset();
            ce    = ($urandom_range(0, 7) != 0);
            tick  = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            fs    = ($urandom_range(0, 63) == 0);
            waddr = 6'($urandom);
            wdata = $urandom;
            be    = 4'($urandom);
            ra1   = ($urandom_range(0, 3) == 0) ? waddr : 6'($urandom);
            ra2   = 6'($urandom);
            cs1   = ($urandom_range(0, 7) == 0);
            cs2   = ($urandom_range(0, 7) == 0);
            fv    = $urandom;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
